bounce_arbiter: RTL and testbench

- N-requester arbiter that grants one shared resource at a time.
- Fairness comes from a one-hot priority pointer that bounces MSB→LSB→MSB, one step per completed grant.
- Grants are held until the owner releases the resource, the owner drops its request, or a hold-limit timeout fires.
- Sits in front of any shared datapath resource in the scanner/display subsystem.

---
 rtl/bounce_arbiter_pkg.sv | 19 +
 rtl/bounce_arbiter_ptr.sv | 54 +++++
 rtl/bounce_arbiter.sv | 132 +++++++++++++
 tb/tb_bounce_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_arbiter_pkg.sv
// Shared definitions for the bounce arbiter: FSM state encoding, pointer
// direction constants and the pointer reset-value helper.
package bounce_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  // Direction of pointer travel: right = decreasing index.
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  // One-hot value with only bit n-1 set; callers size-cast to their width.
  function automatic logic [31:0] ptr_msb(input int n);
    return 32'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/bounce_arbiter_ptr.sv
// bounce_ptr: one-hot priority pointer that bounces MSB->LSB->MSB, one step
// per advance strobe.
// Ports:
//   CLK, RSTna  clock (rising edge), asynchronous active-low reset
//   adv         advance strobe, one step per cycle it is high
//   ptr         one-hot pointer, resets to the MSB
//   dir         current direction (DIR_RIGHT / DIR_LEFT)
//   tc          one-cycle pulse when the pointer turns at the LSB
module bounce_ptr
  import bounce_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RSTna,
  input  logic         adv,
  output logic [N-1:0] ptr,
  output logic         dir,
  output logic         tc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTna) begin
    if (!RSTna) begin
      ptr <= N'(ptr_msb(N));
      dir <= DIR_RIGHT;
      tc  <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (adv) begin
        if (dir == DIR_RIGHT) begin
          if (ptr[0]) begin
            // Turn at the LSB: reverse and step to index 1.
            dir <= DIR_LEFT;
            ptr <= ptr << 1;
            tc  <= 1'b1;
          end else begin
            ptr <= ptr >> 1;
          end
        end else begin
          if (ptr[N-1]) begin
            // Turn at the MSB: reverse and step to index N-2.
            dir <= DIR_RIGHT;
            ptr <= ptr >> 1;
          end else begin
            ptr <= ptr << 1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/bounce_arbiter.sv
// bounce_arbiter: N-requester arbiter for one shared resource. The owner
// keeps the grant until it strobes DONE, drops REQ, or holds for MAXHOLD
// cycles. Fairness comes from a bouncing one-hot priority pointer that
// advances once per release.
// Ports:
//   CLK, RSTna  clock (rising edge), asynchronous active-low reset
//   REQ         per-requester level request
//   DONE        per-requester release strobe (only the owner's bit counts)
//   GNT         registered one-hot grant, zero when idle
//   GNT_IDX     binary index of the owner, holds last owner when idle
//   BUSY        high while a grant is active
//   PTR         one-hot priority pointer
//   TC          one-cycle pulse when the pointer turns at the LSB
//   TIMEOUT     one-cycle pulse on a forced (hold-limit) release
module bounce_arbiter
  import bounce_arbiter_pkg::*;
#(
  parameter int N       = 8,
  parameter int MAXHOLD = 16,
  parameter int W       = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RSTna,
  input  logic [N-1:0] REQ,
  input  logic [N-1:0] DONE,
  output logic [N-1:0] GNT,
  output logic [W-1:0] GNT_IDX,
  output logic         BUSY,
  output logic [N-1:0] PTR,
  output logic         TC,
  output logic         TIMEOUT
);

  localparam int CW = $clog2(MAXHOLD);

  state_t        state;
  logic [CW-1:0] hold_cnt;
  logic          dir;
  logic [W-1:0]  ptr_idx;
  logic [W-1:0]  win_idx;
  logic          win_found;
  logic          at_limit;
  logic          rel_normal;
  logic          rel_timeout;
  logic          rel;

  bounce_ptr #(.N(N)) u_ptr (
    .CLK   (CLK),
    .RSTna (RSTna),
    .adv   (rel),
    .ptr   (PTR),
    .dir   (dir),
    .tc    (TC)
  );

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned (no latch).
  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (PTR[i]) ptr_idx = W'(i);
    end
  end

  // Circular scan starting at the pointer, in the pointer's direction.
  always_comb begin
    int           j;
    logic [W-1:0] jj;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    jj        = '0;
    for (int i = 0; i < N; i++) begin
      if (dir == DIR_RIGHT) begin
        j = int'(ptr_idx) - i;
        if (j < 0) j = j + N;
      end else begin
        j = int'(ptr_idx) + i;
        if (j >= N) j = j - N;
      end
      jj = W'(j);
      if (!win_found && REQ[jj]) begin
        win_found = 1'b1;
        win_idx   = jj;
      end
    end
  end

  // A voluntary release wins over a coincident hold-limit expiry.
  assign at_limit    = (hold_cnt == CW'(MAXHOLD - 1));
  assign rel_normal  = (state == ST_OWNED) && (DONE[GNT_IDX] || !REQ[GNT_IDX]);
  assign rel_timeout = (state == ST_OWNED) && !rel_normal && at_limit;
  assign rel         = rel_normal || rel_timeout;

  // NOTE: the async reset clears GNT/BUSY the moment RSTna falls, without
  // waiting for a clock edge.
  always_ff @(posedge CLK or negedge RSTna) begin
    if (!RSTna) begin
      state    <= ST_IDLE;
      GNT      <= '0;
      GNT_IDX  <= '0;
      BUSY     <= 1'b0;
      TIMEOUT  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      TIMEOUT <= rel_timeout;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            state    <= ST_OWNED;
            GNT      <= N'(1) << win_idx;
            GNT_IDX  <= win_idx;
            BUSY     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ST_OWNED: begin
          if (rel) begin
            // Returning to IDLE forces a one-cycle gap before the next grant.
            state <= ST_IDLE;
            GNT   <= '0;
            BUSY  <= 1'b0;
          end else if (!at_limit) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_arbiter.sv
// Self-checking bench for bounce_arbiter (N=8, MAXHOLD=16). The reference
// model tracks the pointer as a function of the total number of releases.
module tb_bounce_arbiter;

  localparam int N       = 8;
  localparam int MAXHOLD = 16;
  localparam int W       = $clog2(N);
  localparam int PERIOD  = 2 * (N - 1);

  logic         CLK = 1'b0;
  logic         RSTna;
  logic [N-1:0] REQ;
  logic [N-1:0] DONE;
  logic [N-1:0] GNT;
  logic [W-1:0] GNT_IDX;
  logic         BUSY;
  logic [N-1:0] PTR;
  logic         TC;
  logic         TIMEOUT;

  bounce_arbiter #(.N(N), .MAXHOLD(MAXHOLD)) dut (
    .CLK     (CLK),
    .RSTna   (RSTna),
    .REQ     (REQ),
    .DONE    (DONE),
    .GNT     (GNT),
    .GNT_IDX (GNT_IDX),
    .BUSY    (BUSY),
    .PTR     (PTR),
    .TC      (TC),
    .TIMEOUT (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_owned;
  int           m_owner;
  int           m_hold;
  int           m_rel;
  logic [N-1:0] e_gnt;
  int           e_idx;
  bit           e_busy;
  bit           e_to;
  bit           e_tc;

  // Pointer position after r releases: 7,6,...,0,1,...,7,6,...
  function automatic int ptr_pos(input int r);
    int m;
    m = r % PERIOD;
    if (m <= N - 1) return N - 1 - m;
    return m - (N - 1);
  endfunction

  // Rightward travel from reset through the arrival at index 0.
  function automatic bit ptr_right(input int r);
    int m;
    m = r % PERIOD;
    return (r == 0) || (m >= 1 && m <= N - 1);
  endfunction

  function automatic int scan(input logic [N-1:0] req, input int r);
    int p;
    int idx;
    p = ptr_pos(r);
    for (int i = 0; i < N; i++) begin
      idx = ptr_right(r) ? (p - i + N) % N : (p + i) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owned = 0; m_owner = 0; m_hold = 0; m_rel = 0;
    e_gnt = '0; e_idx = 0; e_busy = 0; e_to = 0; e_tc = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] done);
    int w;
    e_to = 0;
    e_tc = 0;
    if (m_owned) begin
      if (done[m_owner] || !req[m_owner]) begin
        m_owned = 0;
        m_rel++;
      end else if (m_hold == MAXHOLD - 1) begin
        m_owned = 0;
        m_rel++;
        e_to = 1;
      end else begin
        m_hold++;
      end
      if (!m_owned) begin
        e_gnt  = '0;
        e_busy = 0;
        if (m_rel % PERIOD == N) e_tc = 1;
      end
    end else begin
      w = scan(req, m_rel);
      if (w >= 0) begin
        m_owned = 1;
        m_owner = w;
        m_hold  = 0;
        e_gnt   = N'(1) << w;
        e_idx   = w;
        e_busy  = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".gnt"},     32'(GNT),              32'(e_gnt));
    check({tag, ".idx"},     32'(GNT_IDX),          32'(e_idx));
    check({tag, ".busy"},    32'(BUSY),             32'(e_busy));
    check({tag, ".ptr"},     32'(PTR),              32'(N'(1) << ptr_pos(m_rel)));
    check({tag, ".tc"},      32'(TC),               32'(e_tc));
    check({tag, ".timeout"}, 32'(TIMEOUT),          32'(e_to));
    check({tag, ".onehot0"}, 32'($countones(GNT) <= 1), 32'd1);
  endtask

  task automatic cycle(input string tag, input logic [N-1:0] req, input logic [N-1:0] done);
    REQ  = req;
    DONE = done;
    model_step(req, done);
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    RSTna = 1'b0;
    REQ   = '0;
    DONE  = '0;
    @(posedge CLK);
    #1;
    model_reset();
    check_all("reset");
    check("reset.ptr_const", 32'(PTR), 32'h80);
    check("reset.gnt_const", 32'(GNT), 32'h0);
    RSTna = 1'b1;
  endtask

  logic [N-1:0] cur_req;
  logic [N-1:0] cur_done;
  int           hi_cnt;
  bit           to_seen;

  initial begin
    do_reset();

    // Basic grant, DONE release, rescan from the advanced pointer.
    cycle("basic.idle", '0, '0);
    cycle("basic.g7", 8'h81, 8'h00);
    check("basic.gnt80", 32'(GNT), 32'h80);
    check("basic.idx7", 32'(GNT_IDX), 32'd7);
    cycle("basic.rel", 8'h81, 8'h80);
    check("basic.ptr40", 32'(PTR), 32'h40);
    check("basic.gap", 32'(GNT), 32'h0);
    cycle("basic.g0", 8'h81, 8'h00);
    check("basic.gnt01", 32'(GNT), 32'h01);
    cycle("basic.drop", 8'h00, 8'h00);

    // Hold-limit timeout with a single persistent requester.
    hi_cnt  = 0;
    to_seen = 0;
    for (int i = 0; i < MAXHOLD + 1; i++) begin
      cycle("hold", 8'h10, 8'h00);
      if (GNT == 8'h10) hi_cnt++;
      if (TIMEOUT) to_seen = 1;
    end
    check("hold.cycles", 32'(hi_cnt), 32'(MAXHOLD));
    check("hold.timeout_last", 32'(TIMEOUT), 32'd1);
    cycle("hold.regrant", 8'h10, 8'h00);
    check("hold.regrant_gnt", 32'(GNT), 32'h10);
    check("hold.to_pulse", 32'(TIMEOUT), 32'd0);
    cycle("hold.drop", 8'h00, 8'h00);

    // Owner drops its request; a non-owner DONE is ignored.
    cycle("own3.g", 8'h08, 8'h00);
    cycle("own3.done5", 8'h08, 8'h20);
    check("own3.kept", 32'(GNT), 32'h08);
    cycle("own3.drop", 8'h00, 8'h00);
    check("own3.no_timeout", 32'(TIMEOUT), 32'd0);
    check("own3.released", 32'(BUSY), 32'd0);

    // Full pointer bounce from reset.
    do_reset();
    for (int r = 1; r <= PERIOD + 1; r++) begin
      cycle("bounce.g", 8'h01, 8'h00);
      cycle("bounce.r", 8'h01, 8'h01);
      if (r == N - 1) begin
        check("bounce.at_lsb", 32'(PTR), 32'h01);
        check("bounce.no_tc", 32'(TC), 32'd0);
      end
      if (r == N) begin
        check("bounce.turn", 32'(PTR), 32'h02);
        check("bounce.tc", 32'(TC), 32'd1);
      end
      if (r == PERIOD) check("bounce.at_msb", 32'(PTR), 32'h80);
      if (r == PERIOD + 1) check("bounce.goes_right", 32'(PTR), 32'h40);
    end

    // All requesting, each owner releases after one cycle.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle("all.g", 8'hFF, 8'h00);
      cycle("all.r", 8'hFF, 8'hFF);
    end

    // Asynchronous reset in the middle of a grant.
    cycle("arst.g", 8'h04, 8'h00);
    #2;
    RSTna = 1'b0;
    #1;
    check("arst.gnt", 32'(GNT), 32'h0);
    check("arst.busy", 32'(BUSY), 32'd0);
    check("arst.ptr", 32'(PTR), 32'h80);
    @(posedge CLK);
    #1;
    RSTna = 1'b1;
    model_reset();
    check_all("arst.post");

    // Randomized traffic; requests persist for stretches so timeouts occur.
    cur_req = '0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) cur_req = N'($urandom);
      cur_done = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      cycle("rand", cur_req, cur_done);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
